lfsr_prbs_checker: RTL

LFSR_PRBS_CHECKER -- requirements
Module: lfsr_prbs_checker

---
 rtl/lfsr_prbs_checker.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker: acquires, verifies, then free-runs a Fibonacci LFSR.
// Optional per-bit counter enabled with `define LFSR_CHK_BITCNT_EN.
module lfsr_prbs_checker #(
    parameter int          LENGTH      = 16,
    parameter int unsigned TAPS        = 53256,
    parameter int          SYNC_GOOD   = 32,
    parameter int          LOSS_THRESH = 4,
    parameter int          ERR_W       = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [LENGTH-1:0] TAP_MASK = LENGTH'(TAPS);
    localparam int FW = $clog2(LENGTH + 1);
    localparam int GW = $clog2(SYNC_GOOD + 1);
    localparam int MW = $clog2(LOSS_THRESH + 1);
    localparam logic [FW-1:0] LAST_FILL = FW'(LENGTH - 1);
    localparam logic [GW-1:0] LAST_GOOD = GW'(SYNC_GOOD - 1);
    localparam logic [MW-1:0] LAST_MISS = MW'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {
        ACQUIRE,
        VERIFY,
        LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [LENGTH-1:0] h_q, h_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [GW-1:0]     good_q, good_d;
    logic [MW-1:0]     miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic              pred;
    logic              match;

    assign pred  = ^{TAP_MASK & h_q, h_q[0]};
    assign match = (in_bit == pred);

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        fill_d      = fill_q;
        good_d      = good_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        if (in_valid) begin
            case (state_q)
                ACQUIRE: begin
                    h_d = {in_bit, h_q[LENGTH-1:1]};
                    if (fill_q == LAST_FILL) begin
                        fill_d  = '0;
                        good_d  = '0;
                        state_d = VERIFY;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                VERIFY: begin
                    h_d = {in_bit, h_q[LENGTH-1:1]};
                    // An all-zero history predicts zero forever; never count it.
                    if (!match || h_q == '0) begin
                        good_d = '0;
                    end else if (good_q == LAST_GOOD) begin
                        good_d  = '0;
                        miss_d  = '0;
                        state_d = LOCKED;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                LOCKED: begin
                    h_d = {pred, h_q[LENGTH-1:1]};
                    if (!match) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (miss_q == LAST_MISS) begin
                            miss_d  = '0;
                            fill_d  = '0;
                            good_d  = '0;
                            state_d = ACQUIRE;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                end
            endcase
        end
        if (clr_cnt) begin
            err_count_d = '0;
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACQUIRE;
            h_q         <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

`ifdef LFSR_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    always_comb begin
        bit_count_d = bit_count_q;
        if (in_valid && state_q == LOCKED) begin
            bit_count_d = bit_count_q + 1'b1;
        end
        if (clr_cnt) begin
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_count_q <= '0;
        end else begin
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_count = bit_count_q;
`else
    assign bit_count = '0;
`endif

endmodule
